// File: rtl/slot_responder_if.sv
`default_nettype none
// slot_responder_if: AXI4-Lite channel bundle (64-bit data) between a requester and the slot responder.
// rev 1.0
interface slot_responder_if;
  logic [63:0] SLOT_awaddr;
  logic [2:0]  SLOT_awprot;
  logic        SLOT_awvalid;
  logic        SLOT_awready;
  logic [63:0] SLOT_wdata;
  logic [7:0]  SLOT_wstrb;
  logic        SLOT_wvalid;
  logic        SLOT_wready;
  logic [1:0]  SLOT_bresp;
  logic        SLOT_bvalid;
  logic        SLOT_bready;
  logic [63:0] SLOT_araddr;
  logic [2:0]  SLOT_arprot;
  logic        SLOT_arvalid;
  logic        SLOT_arready;
  logic [63:0] SLOT_rdata;
  logic [1:0]  SLOT_rresp;
  logic        SLOT_rvalid;
  logic        SLOT_rready;

  modport master (
    output SLOT_awaddr, SLOT_awprot, SLOT_awvalid, SLOT_wdata, SLOT_wstrb, SLOT_wvalid,
           SLOT_bready, SLOT_araddr, SLOT_arprot, SLOT_arvalid, SLOT_rready,
    input  SLOT_awready, SLOT_wready, SLOT_bresp, SLOT_bvalid, SLOT_arready,
           SLOT_rdata, SLOT_rresp, SLOT_rvalid
  );

  modport slave (
    input  SLOT_awaddr, SLOT_awprot, SLOT_awvalid, SLOT_wdata, SLOT_wstrb, SLOT_wvalid,
           SLOT_bready, SLOT_araddr, SLOT_arprot, SLOT_arvalid, SLOT_rready,
    output SLOT_awready, SLOT_wready, SLOT_bresp, SLOT_bvalid, SLOT_arready,
           SLOT_rdata, SLOT_rresp, SLOT_rvalid
  );
endinterface
`default_nettype wire

// File: rtl/slot_responder.sv
`default_nettype none
// slot_responder: AXI4-Lite slave holding DEPTH byte-writable 64-bit words, independent read/write FSMs.
// rev 1.0
module slot_responder #(
  parameter logic [63:0] BASE_ADDR = 64'h0,
  parameter int          DEPTH     = 16
) (
  input  wire               sys_clk_clk_p,
  input  wire               sys_rst_n,
  slot_responder_if.slave   slot,
  output logic [15:0]       err_count
);
  localparam int          IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
  localparam logic [1:0]  OKAY  = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HAVE_AW, W_HAVE_W, W_RESP} wstate_e;
  typedef enum logic [0:0] {R_IDLE, R_RESP} rstate_e;

  wstate_e     w_state_q, w_state_d;
  rstate_e     r_state_q, r_state_d;
  logic        awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [1:0]  bresp_q, bresp_d, rresp_q, rresp_d;
  logic [63:0] awaddr_q, awaddr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [7:0]  wstrb_q, wstrb_d;
  logic        arready_q, arready_d, rvalid_q, rvalid_d;
  logic [15:0] err_q, err_d;
  logic [63:0] mem_q [DEPTH];

  logic        aw_hs, w_hs, ar_hs, w_done, w_in, r_in, b_err, r_err;
  logic [63:0] w_addr, w_data, w_off, r_off;
  logic [7:0]  w_strb;
  logic [16:0] err_sum;
  logic        unused_ok;

  assign aw_hs = slot.SLOT_awvalid && awready_q;
  assign w_hs  = slot.SLOT_wvalid  && wready_q;
  assign ar_hs = slot.SLOT_arvalid && arready_q;

  // The write commits from whichever channel arrived earlier (latched) or now (live).
  assign w_addr = (w_state_q == W_HAVE_AW) ? awaddr_q : slot.SLOT_awaddr;
  assign w_data = (w_state_q == W_HAVE_W)  ? wdata_q  : slot.SLOT_wdata;
  assign w_strb = (w_state_q == W_HAVE_W)  ? wstrb_q  : slot.SLOT_wstrb;
  assign w_off  = w_addr - BASE_ADDR;
  assign r_off  = slot.SLOT_araddr - BASE_ADDR;
  assign w_in   = (w_addr >= BASE_ADDR) && (w_off < SPAN);
  assign r_in   = (slot.SLOT_araddr >= BASE_ADDR) && (r_off < SPAN);
  assign unused_ok = ^{slot.SLOT_awprot, slot.SLOT_arprot, w_off[2:0], r_off[2:0]};

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    w_done    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          w_done = 1'b1;
        end else if (aw_hs) begin
          w_state_d = W_HAVE_AW;
          awaddr_d  = slot.SLOT_awaddr;
        end else if (w_hs) begin
          w_state_d = W_HAVE_W;
          wdata_d   = slot.SLOT_wdata;
          wstrb_d   = slot.SLOT_wstrb;
        end
      end
      W_HAVE_AW: w_done = w_hs;
      W_HAVE_W:  w_done = aw_hs;
      default: begin
        if (bvalid_q && slot.SLOT_bready) begin
          w_state_d = W_IDLE;
          bvalid_d  = 1'b0;
        end
      end
    endcase
    if (w_done) begin
      w_state_d = W_RESP;
      bvalid_d  = 1'b1;
      bresp_d   = w_in ? OKAY : SLVERR;
    end
    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_W);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_HAVE_AW);
  end

  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    if (r_state_q == R_IDLE) begin
      if (ar_hs) begin
        r_state_d = R_RESP;
        rvalid_d  = 1'b1;
        rresp_d   = r_in ? OKAY : SLVERR;
        rdata_d   = r_in ? mem_q[r_off[IDX_W+2:3]] : 64'h0;
      end
    end else if (rvalid_q && slot.SLOT_rready) begin
      r_state_d = R_IDLE;
      rvalid_d  = 1'b0;
    end
    arready_d = (r_state_d == R_IDLE);
  end

  assign b_err   = w_done && !w_in;
  assign r_err   = (r_state_q == R_IDLE) && ar_hs && !r_in;
  assign err_sum = {1'b0, err_q} + 17'(b_err) + 17'(r_err);
  assign err_d   = err_sum[16] ? 16'hFFFF : err_sum[15:0];

  always_ff @(posedge sys_clk_clk_p) begin
    if (!sys_rst_n) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      rresp_q   <= 2'b00;
      awaddr_q  <= 64'h0;
      wdata_q   <= 64'h0;
      wstrb_q   <= 8'h0;
      rdata_q   <= 64'h0;
      err_q     <= 16'h0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 64'h0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      bvalid_q  <= bvalid_d;
      rvalid_q  <= rvalid_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      // Non-blocking update gives read-before-write when AR samples the same word this edge.
      if (w_done && w_in) begin
        for (int b = 0; b < 8; b++) begin
          if (w_strb[b]) mem_q[w_off[IDX_W+2:3]][8*b +: 8] <= w_data[8*b +: 8];
        end
      end
    end
  end

  assign slot.SLOT_awready = awready_q;
  assign slot.SLOT_wready  = wready_q;
  assign slot.SLOT_bvalid  = bvalid_q;
  assign slot.SLOT_bresp   = bresp_q;
  assign slot.SLOT_arready = arready_q;
  assign slot.SLOT_rvalid  = rvalid_q;
  assign slot.SLOT_rresp   = rresp_q;
  assign slot.SLOT_rdata   = rdata_q;
  assign err_count         = err_q;
endmodule
`default_nettype wire

// File: tb/tb_slot_responder.sv
`timescale 1ns/1ps
`default_nettype none
// tb_slot_responder: directed scoreboard bench for slot_responder.
// rev 1.0
module tb_slot_responder;
  localparam logic [63:0] BASE  = 64'h1000;
  localparam int          DEPTH = 16;

  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] data;
  } rexp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] err_count;
  int          checks   = 0;
  int          failures = 0;
  int          exp_err  = 0;
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [63:0] model [DEPTH];

  slot_responder_if slot();

  slot_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .sys_clk_clk_p(clk),
    .sys_rst_n    (rst_n),
    .slot         (slot),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic bit in_rng(input logic [63:0] a);
    return (a >= BASE) && (a < BASE + 64'(8 * DEPTH));
  endfunction

  function automatic int widx(input logic [63:0] a);
    return int'((a - BASE) >> 3);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_write(input logic [63:0] addr, input logic [63:0] data, input logic [7:0] strb);
    if (in_rng(addr)) begin
      bq.push_back(2'b00);
      for (int b = 0; b < 8; b++)
        if (strb[b]) model[widx(addr)][8*b +: 8] = data[8*b +: 8];
    end else begin
      bq.push_back(2'b10);
      exp_err++;
    end
  endtask

  task automatic exp_read(input logic [63:0] addr);
    rexp_t e;
    if (in_rng(addr)) begin
      e.resp = 2'b00;
      e.data = model[widx(addr)];
    end else begin
      e.resp = 2'b10;
      e.data = 64'h0;
      exp_err++;
    end
    rq.push_back(e);
  endtask

  task automatic recv_b(input string tag);
    logic [1:0] e;
    for (int n = 0; n < 20 && !slot.SLOT_bvalid; n++) tick();
    check({tag, "_bvalid"}, slot.SLOT_bvalid, 1);
    check({tag, "_bsb"}, 64'(bq.size() != 0), 1);
    if (bq.size() != 0) begin
      e = bq.pop_front();
      check({tag, "_bresp"}, slot.SLOT_bresp, e);
    end
    slot.SLOT_bready = 1'b1;
    tick();
    slot.SLOT_bready = 1'b0;
    check({tag, "_berr"}, err_count, exp_err);
  endtask

  task automatic recv_r(input string tag);
    rexp_t e;
    for (int n = 0; n < 20 && !slot.SLOT_rvalid; n++) tick();
    check({tag, "_rvalid"}, slot.SLOT_rvalid, 1);
    check({tag, "_rsb"}, 64'(rq.size() != 0), 1);
    if (rq.size() != 0) begin
      e = rq.pop_front();
      check({tag, "_rdata"}, slot.SLOT_rdata, e.data);
      check({tag, "_rresp"}, slot.SLOT_rresp, e.resp);
    end
    slot.SLOT_rready = 1'b1;
    tick();
    slot.SLOT_rready = 1'b0;
    check({tag, "_rerr"}, err_count, exp_err);
  endtask

  task automatic do_write(input string tag, input logic [63:0] addr, input logic [63:0] data,
                          input logic [7:0] strb);
    for (int n = 0; n < 20 && !(slot.SLOT_awready && slot.SLOT_wready); n++) tick();
    check({tag, "_wrdy"}, 64'(slot.SLOT_awready && slot.SLOT_wready), 1);
    slot.SLOT_awvalid = 1'b1; slot.SLOT_awaddr = addr;
    slot.SLOT_wvalid  = 1'b1; slot.SLOT_wdata  = data; slot.SLOT_wstrb = strb;
    exp_write(addr, data, strb);
    tick();
    slot.SLOT_awvalid = 1'b0;
    slot.SLOT_wvalid  = 1'b0;
    check({tag, "_blat"}, slot.SLOT_bvalid, 1);
    recv_b(tag);
  endtask

  task automatic do_read(input string tag, input logic [63:0] addr);
    for (int n = 0; n < 20 && !slot.SLOT_arready; n++) tick();
    check({tag, "_arrdy"}, slot.SLOT_arready, 1);
    slot.SLOT_arvalid = 1'b1; slot.SLOT_araddr = addr;
    exp_read(addr);
    tick();
    slot.SLOT_arvalid = 1'b0;
    check({tag, "_rlat"}, slot.SLOT_rvalid, 1);
    recv_r(tag);
  endtask

  initial begin
    logic [1:0] eb;
    rexp_t      er;
    slot.SLOT_awaddr = '0; slot.SLOT_awprot = '0; slot.SLOT_awvalid = 1'b0;
    slot.SLOT_wdata  = '0; slot.SLOT_wstrb  = '0; slot.SLOT_wvalid  = 1'b0;
    slot.SLOT_bready = 1'b0;
    slot.SLOT_araddr = '0; slot.SLOT_arprot = 3'b101; slot.SLOT_arvalid = 1'b0;
    slot.SLOT_rready = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = 64'h0;

    // Reset values
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_bvalid", slot.SLOT_bvalid, 0);
    check("rst_rvalid", slot.SLOT_rvalid, 0);
    check("rst_awready", slot.SLOT_awready, 0);
    check("rst_wready", slot.SLOT_wready, 0);
    check("rst_arready", slot.SLOT_arready, 0);
    check("rst_err", err_count, 0);
    check("rst_rdata", slot.SLOT_rdata, 0);
    check("rst_bresp", slot.SLOT_bresp, 0);
    rst_n = 1'b1;
    tick();
    check("post_awready", slot.SLOT_awready, 1);
    check("post_wready", slot.SLOT_wready, 1);
    check("post_arready", slot.SLOT_arready, 1);

    // AW+W same cycle, then read back
    do_write("t27w", BASE + 8, 64'h1122334455667788, 8'hFF);
    do_read("t27r", BASE + 8);

    // W three cycles ahead of AW, partial strobe
    slot.SLOT_wvalid = 1'b1; slot.SLOT_wdata = 64'hAAAAAAAA_BBBBBBBB; slot.SLOT_wstrb = 8'h0F;
    tick();
    slot.SLOT_wvalid = 1'b0;
    check("t28_wready", slot.SLOT_wready, 0);
    check("t28_awready", slot.SLOT_awready, 1);
    check("t28_nob", slot.SLOT_bvalid, 0);
    tick();
    tick();
    slot.SLOT_awvalid = 1'b1; slot.SLOT_awaddr = BASE + 8; slot.SLOT_awprot = 3'b111;
    exp_write(BASE + 8, 64'hAAAAAAAA_BBBBBBBB, 8'h0F);
    tick();
    slot.SLOT_awvalid = 1'b0;
    check("t28_blat", slot.SLOT_bvalid, 1);
    check("t28_awready_busy", slot.SLOT_awready, 0);
    recv_b("t28");
    check("t28_awready_back", slot.SLOT_awready, 1);
    do_read("t28r", BASE + 8);
    check("t28_model", model[1], 64'h11223344_BBBBBBBB);

    // Out-of-range decode
    do_read("t29r", BASE + 8 * DEPTH);
    do_write("t29w", BASE + 8 * DEPTH, 64'hDEADBEEF_0BADF00D, 8'hFF);
    do_read("t29lo", BASE - 8);
    do_read("t29w1", BASE + 8);
    do_read("t29w15", BASE + 8 * (DEPTH - 1));

    // Concurrent write+read with stalled bready/rready
    slot.SLOT_awvalid = 1'b1; slot.SLOT_awaddr = BASE + 16;
    slot.SLOT_wvalid  = 1'b1; slot.SLOT_wdata  = 64'hCAFEF00D_00001234; slot.SLOT_wstrb = 8'hFF;
    slot.SLOT_arvalid = 1'b1; slot.SLOT_araddr = BASE + 8;
    exp_read(BASE + 8);
    exp_write(BASE + 16, 64'hCAFEF00D_00001234, 8'hFF);
    tick();
    slot.SLOT_awvalid = 1'b0; slot.SLOT_wvalid = 1'b0; slot.SLOT_arvalid = 1'b0;
    eb = bq.pop_front();
    er = rq.pop_front();
    for (int i = 0; i < 4; i++) begin
      check("t30_bvalid", slot.SLOT_bvalid, 1);
      check("t30_bresp", slot.SLOT_bresp, eb);
      check("t30_awready", slot.SLOT_awready, 0);
      check("t30_wready", slot.SLOT_wready, 0);
      check("t30_rvalid", slot.SLOT_rvalid, 1);
      check("t30_rdata", slot.SLOT_rdata, er.data);
      check("t30_rresp", slot.SLOT_rresp, er.resp);
      check("t30_arready", slot.SLOT_arready, 0);
      tick();
    end
    slot.SLOT_rready = 1'b1;
    tick();
    slot.SLOT_rready = 1'b0;
    check("t30_rdone", slot.SLOT_rvalid, 0);
    check("t30_arready_back", slot.SLOT_arready, 1);
    check("t30_bhold", slot.SLOT_bvalid, 1);
    slot.SLOT_bready = 1'b1;
    tick();
    slot.SLOT_bready = 1'b0;
    check("t30_bdone", slot.SLOT_bvalid, 0);
    check("t30_awready_back", slot.SLOT_awready, 1);
    do_read("t30r", BASE + 16);

    // Write commit and AR to the same word on the same edge
    slot.SLOT_awvalid = 1'b1; slot.SLOT_awaddr = BASE + 24;
    slot.SLOT_wvalid  = 1'b1; slot.SLOT_wdata  = 64'h5; slot.SLOT_wstrb = 8'hFF;
    slot.SLOT_arvalid = 1'b1; slot.SLOT_araddr = BASE + 24;
    exp_read(BASE + 24);
    exp_write(BASE + 24, 64'h5, 8'hFF);
    tick();
    slot.SLOT_awvalid = 1'b0; slot.SLOT_wvalid = 1'b0; slot.SLOT_arvalid = 1'b0;
    recv_r("t31old");
    recv_b("t31");
    do_read("t31new", BASE + 24);

    // Reset with write in W_HAVE_AW and a read response pending
    slot.SLOT_awvalid = 1'b1; slot.SLOT_awaddr = BASE + 32;
    tick();
    slot.SLOT_awvalid = 1'b0;
    check("t32_haveaw_awready", slot.SLOT_awready, 0);
    check("t32_haveaw_wready", slot.SLOT_wready, 1);
    slot.SLOT_arvalid = 1'b1; slot.SLOT_araddr = BASE + 8;
    tick();
    slot.SLOT_arvalid = 1'b0;
    check("t32_rpend", slot.SLOT_rvalid, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_err = 0;
    for (int i = 0; i < DEPTH; i++) model[i] = 64'h0;
    check("t32_bvalid", slot.SLOT_bvalid, 0);
    check("t32_rvalid", slot.SLOT_rvalid, 0);
    check("t32_err", err_count, 0);
    tick();
    check("t32_awready", slot.SLOT_awready, 1);
    for (int i = 0; i < DEPTH; i++) do_read("t32rd", BASE + 64'(8 * i));
    do_write("t32w", BASE + 32, 64'h0123456789ABCDEF, 8'h00);
    do_read("t32strb0", BASE + 32);

    check("sb_empty", 64'(bq.size() + rq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
